// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: architectural widths and the writeback request record.
package ooo_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after the pointer wins;
// the pointer moves just past the winner, so every requester is served within N grants.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  valid,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] ptr;

    // N is a power of two, so the IW-bit add wraps the search naturally.
    always_comb begin
        logic [IW-1:0] j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = ptr + IW'(k);
            if (!any && valid[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
        if (any) grant[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)      ptr <= '0;
        else if (any) ptr <= idx + IW'(1);
    end
endmodule

// File: rtl/writeback_stage.sv
// Writeback: round-robin pick of one FU result per cycle, registered into the
// register-file write port and the scoreboard clear port.
module writeback_stage #(
    parameter int NUM_FU         = 4,
    parameter int DATA_WIDTH     = ooo_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = ooo_pkg::REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FU-1:0]                fu_valid_i,
    output logic [NUM_FU-1:0]                fu_ready_o,
    input  logic [NUM_FU*REG_ADDR_WIDTH-1:0] fu_rd_i,
    input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_data_i,
    output logic                             rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0]        rf_waddr_o,
    output logic [DATA_WIDTH-1:0]            rf_wdata_o,
    output logic                             sb_clr_o,
    output logic [REG_ADDR_WIDTH-1:0]        sb_clr_addr_o,
    output logic [CNT_WIDTH-1:0]             retired_cnt_o
);
    import ooo_pkg::*;

    localparam int IW = $clog2(NUM_FU);

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } wb_t;

    logic [NUM_FU-1:0][REG_ADDR_WIDTH-1:0] rd_arr;
    logic [NUM_FU-1:0][DATA_WIDTH-1:0]     data_arr;
    logic [NUM_FU-1:0]                     grant;
    logic [IW-1:0]                         gidx;
    logic                                  gany;
    wb_t                                   sel, wb_q;
    logic                                  wr_q;
    logic [CNT_WIDTH-1:0]                  cnt_q;

    assign rd_arr   = fu_rd_i;
    assign data_arr = fu_data_i;

    rr_arbiter #(.N(NUM_FU)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (fu_valid_i),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign fu_ready_o = rst ? '0 : grant;
    assign sel.rd     = rd_arr[gidx];
    assign sel.data   = data_arr[gidx];

    // x0 results are retired and counted but never written or cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q  <= '0;
            wr_q  <= 1'b0;
            cnt_q <= '0;
        end else if (gany) begin
            wb_q  <= sel;
            wr_q  <= (sel.rd != '0);
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end else begin
            wr_q  <= 1'b0;
        end
    end

    // Strobes are squashed during reset so a write pending at reset never lands.
    assign rf_we_o       = wr_q & ~rst;
    assign sb_clr_o      = wr_q & ~rst;
    assign rf_waddr_o    = wb_q.rd;
    assign sb_clr_addr_o = wb_q.rd;
    assign rf_wdata_o    = wb_q.data;
    assign retired_cnt_o = cnt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand sequences and random traffic
// against a queue-free reference model of the round-robin retire rules.
module tb_writeback_stage;
    localparam int N = 4, DW = 32, AW = 5, CW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]         fu_valid = '0;
    logic [N-1:0]         fu_ready;
    logic [N-1:0][AW-1:0] fu_rd    = '0;
    logic [N-1:0][DW-1:0] fu_data  = '0;
    logic                 rf_we, sb_clr;
    logic [AW-1:0]        rf_waddr, sb_addr;
    logic [DW-1:0]        rf_wdata;
    logic [CW-1:0]        cnt;

    writeback_stage #(.NUM_FU(N), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .fu_valid_i(fu_valid), .fu_ready_o(fu_ready),
        .fu_rd_i(fu_rd), .fu_data_i(fu_data), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr),
        .rf_wdata_o(rf_wdata), .sb_clr_o(sb_clr), .sb_clr_addr_o(sb_addr),
        .retired_cnt_o(cnt)
    );

    int tests = 0, fails = 0;

    // reference state
    int            mptr = 0;
    logic          mwe  = 1'b0;
    logic [AW-1:0] maddr = '0;
    logic [DW-1:0] mdata = '0;
    logic [CW-1:0] mcnt  = '0;
    int            last_g;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (rst) return -1;
        for (int k = 0; k < N; k++)
            if (fu_valid[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    task automatic half_check();
        int g;
        logic [N-1:0] er;
        @(negedge clk);
        g  = model_grant();
        er = (g < 0) ? '0 : (N'(1) << g);
        chk("ready", fu_ready, er);
        chk("rf_we", rf_we, mwe && !rst);
        chk("sb_clr", sb_clr, mwe && !rst);
        chk("rf_waddr", rf_waddr, maddr);
        chk("sb_addr", sb_addr, maddr);
        chk("rf_wdata", rf_wdata, mdata);
        chk("retired_cnt", cnt, mcnt);
    endtask

    task automatic half_step();
        int g;
        @(posedge clk);
        g = model_grant();
        if (rst) begin
            mptr = 0; mwe = 1'b0; maddr = '0; mdata = '0; mcnt = '0;
        end else if (g >= 0) begin
            mwe   = (fu_rd[g] != '0);
            maddr = fu_rd[g];
            mdata = fu_data[g];
            mcnt  = mcnt + 1;
            mptr  = (g + 1) % N;
        end else begin
            mwe = 1'b0;
        end
        last_g = g;
        #1;
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
    } vec_t;

    vec_t          vt[12];
    logic [N-1:0]  pend;
    int            dup;

    initial begin
        vt[0]  = '{4'b1111, 4'b0001}; vt[1]  = '{4'b1111, 4'b0010};
        vt[2]  = '{4'b1111, 4'b0100}; vt[3]  = '{4'b1111, 4'b1000};
        vt[4]  = '{4'b1111, 4'b0001}; vt[5]  = '{4'b1111, 4'b0010};
        vt[6]  = '{4'b0000, 4'b0000}; vt[7]  = '{4'b0011, 4'b0001};
        vt[8]  = '{4'b0011, 4'b0010}; vt[9]  = '{4'b1001, 4'b1000};
        vt[10] = '{4'b1001, 4'b0001}; vt[11] = '{4'b0100, 4'b0100};

        // reset with everything valid
        fu_valid = '1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            half_check();
            chk("rst_ready", fu_ready, 0);
            chk("rst_we", rf_we, 0);
            chk("rst_cnt", cnt, 0);
            half_step();
        end

        // single result from FU1
        rst = 1'b0;
        fu_valid = 4'b0010; fu_rd[1] = 5; fu_data[1] = 32'hDEADBEEF;
        half_check(); chk("t2_ready", fu_ready, 4'b0010); half_step();
        fu_valid = '0;
        half_check();
        chk("t2_we", rf_we, 1); chk("t2_addr", rf_waddr, 5);
        chk("t2_data", rf_wdata, 32'hDEADBEEF); chk("t2_clr", sb_clr, 1);
        chk("t2_clr_addr", sb_addr, 5); chk("t2_cnt", cnt, 1);
        half_step();

        // arbitration table starting from a freshly reset pointer
        rst = 1'b1; half_check(); half_step(); rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            fu_rd[i] = AW'(i + 1); fu_data[i] = DW'(32'h100 * (i + 1));
        end
        foreach (vt[i]) begin
            fu_valid = vt[i].valid;
            half_check();
            chk($sformatf("tbl%0d_ready", i), fu_ready, vt[i].exp_ready);
            half_step();
        end
        fu_valid = '0;
        half_check(); half_step();

        // x0 destination (pointer is at 3, FU0 wins)
        fu_valid = 4'b0001; fu_rd[0] = 0; fu_data[0] = 7;
        half_check(); chk("t4_ready", fu_ready, 4'b0001); half_step();
        fu_valid = '0;
        half_check();
        chk("t4_we", rf_we, 0); chk("t4_clr", sb_clr, 0);
        chk("t4_cnt", cnt, 12); chk("t4_data", rf_wdata, 7);
        half_step();

        // move pointer to 3, then FU2 and FU3 contend
        fu_valid = 4'b0100; fu_rd[2] = 20; fu_data[2] = 1;
        half_check(); half_step();
        fu_valid = 4'b1100; fu_rd[2] = 6; fu_data[2] = 32'hAAAA; fu_rd[3] = 7; fu_data[3] = 32'hBBBB;
        half_check(); chk("t5_first", fu_ready, 4'b1000); half_step();
        fu_valid = 4'b0100;
        half_check();
        chk("t5_second", fu_ready, 4'b0100); chk("t5_addr3", rf_waddr, 7);
        chk("t5_data3", rf_wdata, 32'hBBBB);
        half_step();
        fu_valid = '0;
        half_check(); chk("t5_addr2", rf_waddr, 6); chk("t5_data2", rf_wdata, 32'hAAAA); half_step();

        // reset right after an accept
        fu_valid = 4'b0001; fu_rd[0] = 9; fu_data[0] = 32'h99;
        half_check(); chk("t6_accept", fu_ready, 4'b0001); half_step();
        rst = 1'b1; fu_valid = '1;
        half_check();
        chk("t6_we", rf_we, 0); chk("t6_clr", sb_clr, 0); chk("t6_ready", fu_ready, 0);
        half_step();
        rst = 1'b0; fu_valid = '0;
        half_check(); chk("t6_cnt", cnt, 0); chk("t6_we_after", rf_we, 0); half_step();
        fu_valid = '1;
        half_check(); chk("t6_ptr0", fu_ready, 4'b0001); half_step();
        fu_valid = '0;
        half_check(); half_step();

        // random traffic with held requests and unique destinations
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    logic [AW-1:0] r;
                    bit ok;
                    for (int t = 0; t < 100; t++) begin
                        r  = AW'($urandom_range(0, 31));
                        ok = 1'b1;
                        for (int o = 0; o < N; o++)
                            if (pend[o] && fu_rd[o] == r) ok = 1'b0;
                        if (ok) break;
                    end
                    if (ok) begin
                        pend[i] = 1'b1; fu_rd[i] = r; fu_data[i] = $urandom;
                    end
                end
            end
            fu_valid = pend;
            rst = ($urandom_range(0, 63) == 0);
            dup = 0;
            for (int a = 0; a < N; a++)
                for (int b = a + 1; b < N; b++)
                    if (fu_valid[a] && fu_valid[b] && fu_rd[a] == fu_rd[b]) dup++;
            half_check();
            chk("no_waw", dup, 0);
            half_step();
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        rst = 1'b0; fu_valid = '0;
        half_check(); half_step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
